// File: rtl/fir_meas_pkg.sv
// Shared types and default widths for the FIR response meter.
package fir_meas_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int WIN_W_DEF  = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DONE
  } meas_state_t;

endpackage

// File: rtl/fir_response_meter_zc_detect.sv
// Rising zero-crossing detector: remembers the previous valid sample and
// masks the first sample after a clear, which has no predecessor.
module zc_detect #(
  parameter int DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_rise,
  output logic                     o_first
);

  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     have_prev_q, have_prev_d;

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (i_clear) begin
      have_prev_d = 1'b0;
    end else if (i_valid) begin
      prev_d      = i_data;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  // Sign bits only: prev < 0 and cur >= 0. Idle cycles never update prev.
  assign o_rise  = i_valid && !i_clear && have_prev_q &&
                   prev_q[DATA_W-1] && !i_data[DATA_W-1];
  assign o_first = !have_prev_q;

endmodule

// File: rtl/fir_response_meter.sv
// Windowed response meter: signed max/min, peak-to-peak and rising zero
// crossings over a programmable number of valid samples.
module fir_response_meter
  import fir_meas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  input  logic                     i_start,
  input  logic [WIN_W-1:0]         i_window,
  output logic                     o_busy,
  output logic                     o_done,
  output logic signed [DATA_W-1:0] o_max,
  output logic signed [DATA_W-1:0] o_min,
  output logic [DATA_W:0]          o_pk2pk,
  output logic [CNT_W-1:0]         o_zc_count
);

  meas_state_t              state_q, state_d;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [WIN_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic signed [DATA_W-1:0] run_max_q, run_max_d;
  logic signed [DATA_W-1:0] run_min_q, run_min_d;
  logic [CNT_W-1:0]         zc_q, zc_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [DATA_W-1:0] min_q, min_d;
  logic [DATA_W:0]          pk_q, pk_d;
  logic [CNT_W-1:0]         zc_out_q, zc_out_d;
  logic                     clear;
  logic                     sample_en;
  logic                     rise;
  logic                     first;

  assign sample_en = (state_q == MEASURE) && i_valid;

  zc_detect #(
    .DATA_W(DATA_W)
  ) u_zc_detect (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(clear),
    .i_valid(sample_en),
    .i_data (i_data),
    .o_rise (rise),
    .o_first(first)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    zc_d      = zc_q;
    max_d     = max_q;
    min_d     = min_q;
    pk_d      = pk_q;
    zc_out_d  = zc_out_q;
    clear     = 1'b0;
    cnt_inc   = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (i_start && (i_window != '0)) begin
          state_d = MEASURE;
          win_d   = i_window;
          cnt_d   = '0;
          zc_d    = '0;
          clear   = 1'b1;
        end
      end

      MEASURE: begin
        if (i_valid) begin
          if (first) begin
            run_max_d = i_data;
            run_min_d = i_data;
          end else begin
            if (i_data > run_max_q) run_max_d = i_data;
            if (i_data < run_min_q) run_min_d = i_data;
          end
          if (rise && (zc_q != '1)) zc_d = zc_q + 1'b1;
          cnt_d = cnt_inc;
          // Results are loaded with the last sample so they are visible during DONE.
          if (cnt_inc == win_q) begin
            state_d  = DONE;
            max_d    = run_max_d;
            min_d    = run_min_d;
            pk_d     = {run_max_d[DATA_W-1], run_max_d} - {run_min_d[DATA_W-1], run_min_d};
            zc_out_d = zc_d;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      cnt_q     <= '0;
      run_max_q <= '0;
      run_min_q <= '0;
      zc_q      <= '0;
      max_q     <= '0;
      min_q     <= '0;
      pk_q      <= '0;
      zc_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      zc_q      <= zc_d;
      max_q     <= max_d;
      min_q     <= min_d;
      pk_q      <= pk_d;
      zc_out_q  <= zc_out_d;
    end
  end

  assign o_busy     = (state_q == MEASURE);
  assign o_done     = (state_q == DONE);
  assign o_max      = max_q;
  assign o_min      = min_q;
  assign o_pk2pk    = pk_q;
  assign o_zc_count = zc_out_q;

endmodule

// File: tb/tb_fir_response_meter.sv
// Self-checking bench for fir_response_meter with a queue-based reference model.
module tb_fir_response_meter;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic signed [15:0] i_data;
  logic               i_valid;
  logic               i_start;
  logic [31:0]        i_window;

  logic               o_busy, o_done;
  logic signed [15:0] o_max, o_min;
  logic [16:0]        o_pk2pk;
  logic [31:0]        o_zc_count;

  logic               s_busy, s_done;
  logic signed [15:0] s_max, s_min;
  logic [16:0]        s_pk2pk;
  logic [1:0]         s_zc_count;

  int total = 0;
  int bad   = 0;
  int samples[$];
  int exp_max, exp_min, exp_pk, exp_zc;
  int done_seen, busy_drop;

  fir_response_meter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_start(i_start), .i_window(i_window), .o_busy(o_busy), .o_done(o_done),
    .o_max(o_max), .o_min(o_min), .o_pk2pk(o_pk2pk), .o_zc_count(o_zc_count)
  );

  // Narrow zero-crossing counter instance to exercise saturation.
  fir_response_meter #(.DATA_W(16), .WIN_W(32), .CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_start(i_start), .i_window(i_window), .o_busy(s_busy), .o_done(s_done),
    .o_max(s_max), .o_min(s_min), .o_pk2pk(s_pk2pk), .o_zc_count(s_zc_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic compute_model();
    exp_max = samples[0];
    exp_min = samples[0];
    exp_zc  = 0;
    foreach (samples[i]) begin
      if (samples[i] > exp_max) exp_max = samples[i];
      if (samples[i] < exp_min) exp_min = samples[i];
      if (i > 0 && samples[i-1] < 0 && samples[i] >= 0) exp_zc++;
    end
    exp_pk = exp_max - exp_min;
  endtask

  task automatic start_window(input int w);
    i_start  = 1'b1;
    i_window = 32'(w);
    tick();
    i_start  = 1'b0;
  endtask

  // Idle cycles first, then one valid sample; o_busy/o_done are observed before each edge.
  task automatic drive_sample(input int v, input int gap);
    repeat (gap) begin
      if (o_done) done_seen++;
      if (!o_busy) busy_drop++;
      tick();
    end
    if (o_done) done_seen++;
    if (!o_busy) busy_drop++;
    i_data  = 16'(v);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drive_queue(input int gap_max);
    done_seen = 0;
    busy_drop = 0;
    foreach (samples[i]) drive_sample(samples[i], $urandom_range(0, gap_max));
  endtask

  task automatic test_reset();
    int seen;
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0; i_window = '0;
    repeat (2) tick();
    total++;
    if ({o_busy, o_done, o_max, o_min, o_pk2pk, o_zc_count} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: busy=%0b done=%0b max=%0d min=%0d pk=%0d zc=%0d required all 0",
               o_busy, o_done, o_max, o_min, o_pk2pk, o_zc_count);
    end
    i_rst = 1'b0;
    seen = 0;
    repeat (10) begin
      if (o_done || o_busy) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL reset_quiet: got %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_basic(input int gap, input string name);
    samples = '{5, -3, 7, 0};
    start_window(4);
    done_seen = 0;
    busy_drop = 0;
    foreach (samples[i]) drive_sample(samples[i], gap);
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || done_seen !== 0 || busy_drop !== 0) begin
      bad++;
      $display("[TB] FAIL %s_timing: done=%0b busy=%0b early_done=%0d busy_drop=%0d required 1 0 0 0",
               name, o_done, o_busy, done_seen, busy_drop);
    end
    total++;
    if (o_max !== 16'sd7 || o_min !== -16'sd3) begin
      bad++;
      $display("[TB] FAIL %s_maxmin: got %0d/%0d required 7/-3", name, o_max, o_min);
    end
    total++;
    if (o_pk2pk !== 17'd10 || o_zc_count !== 32'd1) begin
      bad++;
      $display("[TB] FAIL %s_pk_zc: got %0d/%0d required 10/1", name, o_pk2pk, o_zc_count);
    end
    tick();
    total++;
    if (o_done !== 1'b0 || o_max !== 16'sd7 || o_pk2pk !== 17'd10) begin
      bad++;
      $display("[TB] FAIL %s_hold: done=%0b max=%0d pk=%0d required 0 7 10", name, o_done, o_max, o_pk2pk);
    end
  endtask

  task automatic test_full_scale();
    samples = '{32767, -32768};
    start_window(2);
    drive_queue(0);
    total++;
    if (o_done !== 1'b1 || o_max !== 16'sd32767 || o_min !== -16'sd32768 ||
        o_pk2pk !== 17'd65535 || o_zc_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL full_scale: done=%0b max=%0d min=%0d pk=%0d zc=%0d required 1 32767 -32768 65535 0",
               o_done, o_max, o_min, o_pk2pk, o_zc_count);
    end
    tick();
  endtask

  task automatic test_window_zero();
    int seen;
    start_window(0);
    seen = 0;
    repeat (6) begin
      if (o_busy || o_done) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL window_zero: got %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_restart_ignored();
    start_window(4);
    done_seen = 0;
    busy_drop = 0;
    drive_sample(1, 0);
    drive_sample(2, 0);
    start_window(6);
    drive_sample(3, 1);
    drive_sample(4, 0);
    total++;
    if (o_done !== 1'b1 || done_seen !== 0 || o_max !== 16'sd4 || o_min !== 16'sd1) begin
      bad++;
      $display("[TB] FAIL restart_ignored: done=%0b early=%0d max=%0d min=%0d required 1 0 4 1",
               o_done, done_seen, o_max, o_min);
    end
    tick();
  endtask

  task automatic test_abort();
    int seen;
    start_window(4);
    drive_sample(10, 0);
    drive_sample(-10, 0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    total++;
    if ({o_busy, o_done, o_max, o_min, o_pk2pk, o_zc_count} !== '0) begin
      bad++;
      $display("[TB] FAIL abort_outputs: busy=%0b done=%0b max=%0d min=%0d pk=%0d zc=%0d required all 0",
               o_busy, o_done, o_max, o_min, o_pk2pk, o_zc_count);
    end
    seen = 0;
    repeat (6) begin
      if (o_busy || o_done) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet: got %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_saturation();
    samples = '{-1, 0, -2, 5, -7, 0, -1, 1, -3, 3};
    compute_model();
    start_window(samples.size());
    drive_queue(1);
    total++;
    if (o_zc_count !== 32'(exp_zc) || s_zc_count !== 2'(exp_zc > 3 ? 3 : exp_zc)) begin
      bad++;
      $display("[TB] FAIL zc_saturate: wide=%0d narrow=%0d required %0d/%0d",
               o_zc_count, s_zc_count, exp_zc, exp_zc > 3 ? 3 : exp_zc);
    end
    tick();
  endtask

  task automatic test_random();
    logic signed [15:0] raw;
    for (int iter = 0; iter < 10; iter++) begin
      int n;
      n = $urandom_range(1, 24);
      samples.delete();
      for (int k = 0; k < n; k++) begin
        raw = 16'($urandom);
        if ($urandom_range(0, 2) != 0) samples.push_back(int'($urandom_range(0, 60)) - 30);
        else samples.push_back(int'(raw));
      end
      compute_model();
      start_window(n);
      drive_queue(2);
      total++;
      if (o_done !== 1'b1 || done_seen !== 0 || busy_drop !== 0 ||
          o_max !== 16'(exp_max) || o_min !== 16'(exp_min) ||
          o_pk2pk !== 17'(exp_pk) || o_zc_count !== 32'(exp_zc)) begin
        bad++;
        $display("[TB] FAIL random_%0d: done=%0b early=%0d drop=%0d max=%0d min=%0d pk=%0d zc=%0d required 1 0 0 %0d %0d %0d %0d",
                 iter, o_done, done_seen, busy_drop, o_max, o_min, o_pk2pk, o_zc_count,
                 exp_max, exp_min, exp_pk, exp_zc);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    samples = '{-4, 9, -2};
    compute_model();
    start_window(3);
    drive_queue(0);
    start_window(5);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_in_done: busy=%0b done=%0b required 0 0", o_busy, o_done);
    end
    samples = '{100, -100, 50};
    compute_model();
    start_window(3);
    drive_queue(0);
    total++;
    if (o_done !== 1'b1 || o_max !== 16'(exp_max) || o_min !== 16'(exp_min) ||
        o_pk2pk !== 17'(exp_pk) || o_zc_count !== 32'(exp_zc)) begin
      bad++;
      $display("[TB] FAIL back_to_back: done=%0b max=%0d min=%0d pk=%0d zc=%0d required 1 %0d %0d %0d %0d",
               o_done, o_max, o_min, o_pk2pk, o_zc_count, exp_max, exp_min, exp_pk, exp_zc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "gaps");
    test_full_scale();
    test_window_zero();
    test_restart_ignored();
    test_saturation();
    test_random();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
